// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready handshakes on both sides.
// Define ALU_FAST_SHIFT_EN to replace the one-bit-per-cycle shifter with a barrel shifter.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  branch_taken_o,
    output logic                  illegal_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST_SHIFT = 1'b1;
`else
    localparam bit FAST_SHIFT = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LUI = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_BEQ = 4'b1001;
    localparam logic [3:0] OP_BNE = 4'b1010;
    localparam logic [3:0] OP_BLT = 4'b1011;
    localparam logic [3:0] OP_BGE = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  branch_q, branch_d;
    logic                  illegal_q, illegal_d;
    logic [SHW-1:0]        cnt_q, cnt_d;
    logic                  left_q, left_d;

    logic [SHW-1:0]        shamt;
    logic                  isShift;
    logic [DATA_WIDTH-1:0] calcResult;
    logic                  calcBranch;
    logic                  calcIllegal;
    logic [DATA_WIDTH-1:0] shiftedWork;

    assign shamt   = b_i[SHW-1:0];
    assign isShift = (alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL);

    // Single-cycle datapath; in the iterative build a shift only reaches here with shamt == 0.
    always_comb begin
        calcResult  = '0;
        calcBranch  = 1'b0;
        calcIllegal = 1'b0;
        case (alu_operation_i)
            OP_ADD: calcResult = a_i + b_i;
            OP_SUB: calcResult = a_i - b_i;
            OP_AND: calcResult = a_i & b_i;
            OP_OR:  calcResult = a_i | b_i;
            OP_XOR: calcResult = a_i ^ b_i;
            OP_SLL: calcResult = FAST_SHIFT ? (a_i << shamt) : a_i;
            OP_SRL: calcResult = FAST_SHIFT ? (a_i >> shamt) : a_i;
            OP_LUI: calcResult = b_i << 12;
            OP_BEQ: calcBranch = (a_i == b_i);
            OP_BNE: calcBranch = (a_i != b_i);
            OP_BLT: calcBranch = ($signed(a_i) < $signed(b_i));
            OP_BGE: calcBranch = ($signed(a_i) >= $signed(b_i));
            default: calcIllegal = 1'b1;
        endcase
    end

    assign shiftedWork = left_q ? (result_q << 1) : (result_q >> 1);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    branch_d  = calcBranch;
                    illegal_d = calcIllegal;
                    if (!FAST_SHIFT && isShift && (shamt != '0)) begin
                        // result_q doubles as the working register while shifting
                        result_d = a_i;
                        cnt_d    = shamt;
                        left_d   = (alu_operation_i == OP_SLL);
                        state_d  = SHIFT;
                    end else begin
                        result_d = calcResult;
                        zero_d   = (calcResult == '0);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                result_d = shiftedWork;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    zero_d  = (shiftedWork == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
        end
    end

    assign op_ready_o     = (state_q == IDLE);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;
    assign zero_o         = zero_q;
    assign branch_taken_o = branch_q;
    assign illegal_o      = illegal_q;

endmodule
